// File: rtl/eh2_dec_trigger_seq_if.sv
// Trigger packet type plus the bundle of decode-slot, trigger-config and
// trigger-result signals exchanged between decode and the trigger sequencer.
package eh2_dec_trigger_seq_pkg;
  typedef struct packed {
    logic        select;   // 0: compare pc, 1: compare opcode
    logic        match;    // mask-and-match enable
    logic        execute;
    logic        m;
    logic [31:0] tdata2;
  } eh2_trigger_pkt_t;
endpackage

interface eh2_dec_trigger_seq_if #(
  parameter int NUM_THREADS = 1,
  parameter int NUM_TRIG    = 4,
  parameter int NUM_SLOTS   = 2,
  parameter int CNT_W       = 8
);
  import eh2_dec_trigger_seq_pkg::*;

  localparam int TID_W = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1;

  eh2_trigger_pkt_t [NUM_THREADS-1:0][NUM_TRIG-1:0]             trig_pkt;
  logic             [NUM_THREADS-1:0][NUM_TRIG-1:0]             trig_chain;
  logic             [NUM_THREADS-1:0][NUM_TRIG-1:0]             trig_cnt_wr;
  logic             [CNT_W-1:0]                                 trig_cnt_wdata;
  logic             [NUM_SLOTS-1:0]                             slot_valid;
  logic             [NUM_SLOTS-1:0][31:1]                       slot_pc;
  logic             [NUM_SLOTS-1:0][31:0]                       slot_instr;
  logic             [NUM_SLOTS-1:0][TID_W-1:0]                  slot_tid;
  logic             [NUM_THREADS-1:0]                           dec_flush;
  logic             [NUM_SLOTS-1:0][NUM_TRIG-1:0]               trig_match_e;
  logic             [NUM_THREADS-1:0][NUM_TRIG/2-1:0]           trig_armed;
  logic             [NUM_THREADS-1:0][NUM_TRIG-1:0][CNT_W-1:0]  trig_cnt;

  modport master (
    output trig_pkt, trig_chain, trig_cnt_wr, trig_cnt_wdata,
           slot_valid, slot_pc, slot_instr, slot_tid, dec_flush,
    input  trig_match_e, trig_armed, trig_cnt
  );

  modport slave (
    input  trig_pkt, trig_chain, trig_cnt_wr, trig_cnt_wdata,
           slot_valid, slot_pc, slot_instr, slot_tid, dec_flush,
    output trig_match_e, trig_armed, trig_cnt
  );
endinterface

// File: rtl/eh2_dec_trigger_seq.sv
// Decode-stage trigger sequencer: per-slot PC/opcode match, hit counters with
// auto-reload and pairwise chaining; fires are registered into the next cycle.
module eh2_dec_trigger_seq
  import eh2_dec_trigger_seq_pkg::*;
#(
  parameter int NUM_THREADS = 1,
  parameter int NUM_TRIG    = 4,
  parameter int NUM_SLOTS   = 2,
  parameter int CNT_W       = 8
) (
  input logic                  clk,
  input logic                  rst_l,
  eh2_dec_trigger_seq_if.slave bus
);
  localparam int TID_W     = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1;
  localparam int NUM_PAIRS = NUM_TRIG / 2;

  logic [NUM_SLOTS-1:0][NUM_TRIG-1:0]               raw;
  logic [NUM_SLOTS-1:0][NUM_TRIG-1:0]               match_d, match_q;
  logic [NUM_SLOTS-1:0][TID_W-1:0]                  tid_q;
  logic [NUM_THREADS-1:0][NUM_TRIG-1:0][CNT_W-1:0]  cnt_d, cnt_q;
  logic [NUM_THREADS-1:0][NUM_TRIG-1:0][CNT_W-1:0]  reload_d, reload_q;
  logic [NUM_THREADS-1:0][NUM_PAIRS-1:0]            armed_d, armed_q;
  logic [NUM_SLOTS-1:0]                             kill;

  // Bit i becomes don't-care when masking is on and all lower mask bits are ones.
  function automatic logic mask_match(input logic [31:0] mask,
                                      input logic [31:0] data,
                                      input logic        masken);
    logic hit;
    logic low_ones;
    hit      = 1'b1;
    low_ones = 1'b1;
    for (int i = 0; i < 32; i++) begin
      if (i == 0) begin
        if (!(masken && !(&mask)) && (mask[0] != data[0])) hit = 1'b0;
      end else begin
        if (!(masken && low_ones) && (mask[i] != data[i])) hit = 1'b0;
      end
      low_ones = low_ones & mask[i];
    end
    return hit;
  endfunction

  // Returns {fire, next_cnt} for one qualifying match.
  function automatic logic [CNT_W:0] cnt_step(input logic [CNT_W-1:0] cnt,
                                              input logic [CNT_W-1:0] reload);
    if (cnt == '0)
      return {1'b1, cnt};
    else if (cnt == CNT_W'(1))
      return {1'b1, reload};
    else
      return {1'b0, cnt - CNT_W'(1)};
  endfunction

  always_comb begin
    eh2_trigger_pkt_t pkt;
    logic [31:0]      data;
    raw  = '0;
    pkt  = '0;
    data = '0;
    for (int s = 0; s < NUM_SLOTS; s++) begin
      for (int th = 0; th < NUM_THREADS; th++) begin
        if (bus.slot_tid[s] == TID_W'(th)) begin
          for (int t = 0; t < NUM_TRIG; t++) begin
            pkt  = bus.trig_pkt[th][t];
            data = pkt.select ? bus.slot_instr[s] : {bus.slot_pc[s], pkt.tdata2[0]};
            raw[s][t] = bus.slot_valid[s] & pkt.execute & pkt.m & ~bus.dec_flush[th] &
                        mask_match(pkt.tdata2, data, pkt.match);
          end
        end
      end
    end
  end

  // Slots walk in age order so a younger slot sees counters/armed as left by older ones.
  always_comb begin
    logic fire0;
    logic fire1;
    logic chained;
    cnt_d    = cnt_q;
    reload_d = reload_q;
    armed_d  = armed_q;
    match_d  = '0;
    fire0    = 1'b0;
    fire1    = 1'b0;
    chained  = 1'b0;
    for (int th = 0; th < NUM_THREADS; th++) begin
      for (int s = 0; s < NUM_SLOTS; s++) begin
        if (bus.slot_tid[s] == TID_W'(th)) begin
          for (int k = 0; k < NUM_PAIRS; k++) begin
            chained = bus.trig_chain[th][2*k];
            fire0   = 1'b0;
            fire1   = 1'b0;
            // Odd trigger uses the armed state from before this slot's own even fire.
            if (raw[s][2*k+1] && (!chained || armed_d[th][k]))
              {fire1, cnt_d[th][2*k+1]} = cnt_step(cnt_d[th][2*k+1], reload_q[th][2*k+1]);
            if (raw[s][2*k])
              {fire0, cnt_d[th][2*k]} = cnt_step(cnt_d[th][2*k], reload_q[th][2*k]);
            if (chained) begin
              if (fire1) armed_d[th][k] = 1'b0;
              if (fire0) armed_d[th][k] = 1'b1;
              match_d[s][2*k]   = 1'b0;
              match_d[s][2*k+1] = fire1 & ~fire0;
            end else begin
              match_d[s][2*k]   = fire0;
              match_d[s][2*k+1] = fire1;
            end
          end
        end
      end
      for (int t = 0; t < NUM_TRIG; t++) begin
        if (bus.trig_cnt_wr[th][t]) begin
          cnt_d[th][t]    = bus.trig_cnt_wdata;
          reload_d[th][t] = bus.trig_cnt_wdata;
        end
      end
      for (int k = 0; k < NUM_PAIRS; k++) begin
        if (bus.dec_flush[th] || bus.trig_cnt_wr[th][2*k] || bus.trig_cnt_wr[th][2*k+1] ||
            !bus.trig_chain[th][2*k])
          armed_d[th][k] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_l) begin
      match_q  <= '0;
      tid_q    <= '0;
      cnt_q    <= '0;
      reload_q <= '0;
      armed_q  <= '0;
    end else begin
      match_q  <= match_d;
      tid_q    <= bus.slot_tid;
      cnt_q    <= cnt_d;
      reload_q <= reload_d;
      armed_q  <= armed_d;
    end
  end

  // A flush arriving one cycle late still masks the registered fire for that thread.
  always_comb begin
    kill = '0;
    for (int s = 0; s < NUM_SLOTS; s++) begin
      for (int th = 0; th < NUM_THREADS; th++) begin
        if ((tid_q[s] == TID_W'(th)) && bus.dec_flush[th]) kill[s] = 1'b1;
      end
    end
  end

  always_comb begin
    bus.trig_match_e = '0;
    for (int s = 0; s < NUM_SLOTS; s++)
      bus.trig_match_e[s] = match_q[s] & ~{NUM_TRIG{kill[s]}};
  end

  assign bus.trig_armed = armed_q;
  assign bus.trig_cnt   = cnt_q;

endmodule

// File: tb/tb_eh2_dec_trigger_seq.sv
// Scenario bench for eh2_dec_trigger_seq: expected fire vectors are queued as
// each cycle is driven and popped once the registered result appears.
module tb_eh2_dec_trigger_seq;
  import eh2_dec_trigger_seq_pkg::*;

  localparam int NTH = 2;
  localparam int NT  = 4;
  localparam int NS  = 2;
  localparam int CW  = 8;
  localparam int MW  = NS * NT;

  localparam logic [31:0] PC_T0  = 32'h8000_0100;
  localparam logic [31:0] PC_T1  = 32'h8000_0200;
  localparam logic [31:0] PC_TH1 = 32'h8000_0300;
  localparam logic [31:0] PC_OFF = 32'h8000_0400;
  localparam logic [31:0] OPC    = 32'h0050_0093;

  logic clk = 1'b0;
  logic rst_l;
  always #5 clk = ~clk;

  eh2_dec_trigger_seq_if #(.NUM_THREADS(NTH), .NUM_TRIG(NT), .NUM_SLOTS(NS), .CNT_W(CW)) bus();

  eh2_dec_trigger_seq #(.NUM_THREADS(NTH), .NUM_TRIG(NT), .NUM_SLOTS(NS), .CNT_W(CW)) dut (
    .clk   (clk),
    .rst_l (rst_l),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [MW-1:0] exp_q[$];
  logic [MW-1:0] exp_m;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.slot_valid  = '0;
    bus.dec_flush   = '0;
    bus.trig_cnt_wr = '0;
  endtask

  task automatic set_slot(input int s, input logic [31:0] pc, input logic [31:0] instr,
                          input int tid);
    bus.slot_valid[s] = 1'b1;
    bus.slot_pc[s]    = pc[31:1];
    bus.slot_instr[s] = instr;
    bus.slot_tid[s]   = 1'(tid);
  endtask

  task automatic set_trig(input int th, input int t, input logic sel, input logic msk,
                          input logic exe, input logic [31:0] td2);
    eh2_trigger_pkt_t p;
    p.select  = sel;
    p.match   = msk;
    p.execute = exe;
    p.m       = 1'b1;
    p.tdata2  = td2;
    bus.trig_pkt[th][t] = p;
  endtask

  task automatic wr_cnt(input int th, input int t, input logic [CW-1:0] val);
    idle();
    bus.trig_cnt_wr[th][t] = 1'b1;
    bus.trig_cnt_wdata     = val;
    tick();
    idle();
  endtask

  task automatic test_reset();
    n_tests++;
    if (bus.trig_match_e !== '0) begin
      n_fail++; $display("FAIL reset_match: got %h expected 0", bus.trig_match_e);
    end
    n_tests++;
    if (bus.trig_armed !== '0) begin
      n_fail++; $display("FAIL reset_armed: got %h expected 0", bus.trig_armed);
    end
    n_tests++;
    if (bus.trig_cnt !== '0) begin
      n_fail++; $display("FAIL reset_cnt: got %h expected 0", bus.trig_cnt);
    end
  endtask

  task automatic test_pc_match();
    set_trig(0, 0, 1'b0, 1'b0, 1'b1, PC_T0);
    set_trig(0, 1, 1'b1, 1'b0, 1'b1, OPC);
    idle(); set_slot(0, PC_T0, 32'h0, 0); exp_q.push_back(8'h01); tick(); idle();
    exp_m = exp_q.pop_front(); n_tests++;
    if (bus.trig_match_e !== exp_m) begin
      n_fail++; $display("FAIL pc_hit: got %h expected %h", bus.trig_match_e, exp_m);
    end
    set_slot(0, PC_T0 + 32'h4, 32'h0, 0); exp_q.push_back(8'h00); tick(); idle();
    exp_m = exp_q.pop_front(); n_tests++;
    if (bus.trig_match_e !== exp_m) begin
      n_fail++; $display("FAIL pc_miss: got %h expected %h", bus.trig_match_e, exp_m);
    end
    set_slot(1, PC_T0, 32'h0, 0); exp_q.push_back(8'h10); tick(); idle();
    exp_m = exp_q.pop_front(); n_tests++;
    if (bus.trig_match_e !== exp_m) begin
      n_fail++; $display("FAIL pc_hit_slot1: got %h expected %h", bus.trig_match_e, exp_m);
    end
    // flush arriving in the output cycle
    set_slot(0, PC_T0, 32'h0, 0); exp_q.push_back(8'h00);
    @(posedge clk); idle(); bus.dec_flush[0] = 1'b1; #1;
    exp_m = exp_q.pop_front(); n_tests++;
    if (bus.trig_match_e !== exp_m) begin
      n_fail++; $display("FAIL flush_late: got %h expected %h", bus.trig_match_e, exp_m);
    end
    idle(); set_slot(0, PC_T0, 32'h0, 0); bus.dec_flush[0] = 1'b1;
    exp_q.push_back(8'h00); tick(); idle();
    exp_m = exp_q.pop_front(); n_tests++;
    if (bus.trig_match_e !== exp_m) begin
      n_fail++; $display("FAIL flush_same: got %h expected %h", bus.trig_match_e, exp_m);
    end
  endtask

  task automatic test_threads();
    set_trig(1, 0, 1'b0, 1'b0, 1'b1, PC_TH1);
    idle(); set_slot(1, PC_TH1, 32'h0, 1); bus.dec_flush[0] = 1'b1;
    exp_q.push_back(8'h10); tick();
    exp_m = exp_q.pop_front(); n_tests++;
    if (bus.trig_match_e !== exp_m) begin
      n_fail++; $display("FAIL thread1_hit: got %h expected %h", bus.trig_match_e, exp_m);
    end
    idle(); set_slot(0, PC_T0, 32'h0, 1); exp_q.push_back(8'h00); tick(); idle();
    exp_m = exp_q.pop_front(); n_tests++;
    if (bus.trig_match_e !== exp_m) begin
      n_fail++; $display("FAIL thread1_cfg: got %h expected %h", bus.trig_match_e, exp_m);
    end
    set_slot(1, PC_TH1, 32'h0, 1); bus.dec_flush[1] = 1'b1;
    exp_q.push_back(8'h00); tick(); idle();
    exp_m = exp_q.pop_front(); n_tests++;
    if (bus.trig_match_e !== exp_m) begin
      n_fail++; $display("FAIL thread1_flush: got %h expected %h", bus.trig_match_e, exp_m);
    end
    bus.slot_tid = '0;
  endtask

  task automatic test_counter();
    logic [MW-1:0] exp_fire[3];
    logic [CW-1:0] exp_cnt[3];
    exp_fire = '{8'h00, 8'h00, 8'h02};
    exp_cnt  = '{8'd2, 8'd1, 8'd3};
    wr_cnt(0, 1, 8'd3);
    n_tests++;
    if (bus.trig_cnt[0][1] !== 8'd3) begin
      n_fail++; $display("FAIL cnt_load: got %0d expected 3", bus.trig_cnt[0][1]);
    end
    for (int i = 0; i < 3; i++) begin
      set_slot(0, PC_OFF, OPC, 0); exp_q.push_back(exp_fire[i]); tick();
      exp_m = exp_q.pop_front(); n_tests++;
      if (bus.trig_match_e !== exp_m) begin
        n_fail++; $display("FAIL cnt_fire%0d: got %h expected %h", i, bus.trig_match_e, exp_m);
      end
      n_tests++;
      if (bus.trig_cnt[0][1] !== exp_cnt[i]) begin
        n_fail++; $display("FAIL cnt_val%0d: got %0d expected %0d", i, bus.trig_cnt[0][1], exp_cnt[i]);
      end
    end
    // write wins over a same-cycle decrement
    set_slot(0, PC_OFF, OPC, 0); bus.trig_cnt_wr[0][1] = 1'b1; bus.trig_cnt_wdata = 8'd5;
    exp_q.push_back(8'h00); tick(); idle();
    exp_m = exp_q.pop_front(); n_tests++;
    if (bus.trig_match_e !== exp_m || bus.trig_cnt[0][1] !== 8'd5) begin
      n_fail++; $display("FAIL cnt_wr_prio: match %h cnt %0d expected %h cnt 5",
                         bus.trig_match_e, bus.trig_cnt[0][1], exp_m);
    end
  endtask

  task automatic test_dual_slot();
    wr_cnt(0, 1, 8'd2);
    set_slot(0, PC_OFF, OPC, 0); exp_q.push_back(8'h00); tick(); idle();
    exp_m = exp_q.pop_front(); n_tests++;
    if (bus.trig_match_e !== exp_m || bus.trig_cnt[0][1] !== 8'd1) begin
      n_fail++; $display("FAIL dual_prep: match %h cnt %0d expected %h cnt 1",
                         bus.trig_match_e, bus.trig_cnt[0][1], exp_m);
    end
    set_slot(0, PC_OFF, OPC, 0); set_slot(1, PC_OFF, OPC, 0);
    exp_q.push_back(8'h02); tick(); idle();
    exp_m = exp_q.pop_front(); n_tests++;
    if (bus.trig_match_e !== exp_m) begin
      n_fail++; $display("FAIL dual_fire: got %h expected %h", bus.trig_match_e, exp_m);
    end
    n_tests++;
    if (bus.trig_cnt[0][1] !== 8'd1) begin
      n_fail++; $display("FAIL dual_cnt: got %0d expected 1", bus.trig_cnt[0][1]);
    end
    wr_cnt(0, 1, 8'd0);
    set_slot(0, PC_OFF, OPC, 0); set_slot(1, PC_OFF, OPC, 0);
    exp_q.push_back(8'h22); tick(); idle();
    exp_m = exp_q.pop_front(); n_tests++;
    if (bus.trig_match_e !== exp_m || bus.trig_cnt[0][1] !== 8'd0) begin
      n_fail++; $display("FAIL dual_zero: match %h cnt %0d expected %h cnt 0",
                         bus.trig_match_e, bus.trig_cnt[0][1], exp_m);
    end
  endtask

  task automatic test_chain();
    logic [31:0]   pcs[3];
    logic [MW-1:0] exp_fire[3];
    logic [3:0]    exp_arm[3];
    pcs      = '{PC_T1, PC_T0, PC_T1};
    exp_fire = '{8'h00, 8'h00, 8'h02};
    exp_arm  = '{4'b0000, 4'b0001, 4'b0000};
    set_trig(0, 1, 1'b0, 1'b0, 1'b1, PC_T1);
    bus.trig_chain[0][0] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      idle(); set_slot(0, pcs[i], 32'h0, 0); exp_q.push_back(exp_fire[i]); tick(); idle();
      exp_m = exp_q.pop_front(); n_tests++;
      if (bus.trig_match_e !== exp_m || bus.trig_armed !== exp_arm[i]) begin
        n_fail++; $display("FAIL chain_step%0d: match %h armed %b expected %h armed %b",
                           i, bus.trig_match_e, bus.trig_armed, exp_m, exp_arm[i]);
      end
    end
  endtask

  task automatic test_chain_same_cycle();
    set_slot(0, PC_T0, 32'h0, 0); set_slot(1, PC_T1, 32'h0, 0);
    exp_q.push_back(8'h20); tick(); idle();
    exp_m = exp_q.pop_front(); n_tests++;
    if (bus.trig_match_e !== exp_m || bus.trig_armed !== 4'b0000) begin
      n_fail++; $display("FAIL chain_same: match %h armed %b expected %h armed 0000",
                         bus.trig_match_e, bus.trig_armed, exp_m);
    end
    set_slot(0, PC_T0, 32'h0, 0); tick(); idle();
    bus.dec_flush[0] = 1'b1; tick(); idle();
    n_tests++;
    if (bus.trig_armed !== 4'b0000) begin
      n_fail++; $display("FAIL chain_flush_clr: got %b expected 0000", bus.trig_armed);
    end
    set_slot(0, PC_T1, 32'h0, 0); exp_q.push_back(8'h00); tick(); idle();
    exp_m = exp_q.pop_front(); n_tests++;
    if (bus.trig_match_e !== exp_m) begin
      n_fail++; $display("FAIL chain_flush_nofire: got %h expected %h", bus.trig_match_e, exp_m);
    end
    set_slot(0, PC_T0, 32'h0, 0); tick(); idle();
    wr_cnt(0, 1, 8'd0);
    n_tests++;
    if (bus.trig_armed !== 4'b0000) begin
      n_fail++; $display("FAIL chain_wr_clr: got %b expected 0000", bus.trig_armed);
    end
    set_slot(0, PC_T0, 32'h0, 0); tick(); idle();
    bus.trig_chain[0][0] = 1'b0; tick();
    n_tests++;
    if (bus.trig_armed !== 4'b0000) begin
      n_fail++; $display("FAIL chain_off_clr: got %b expected 0000", bus.trig_armed);
    end
    set_slot(0, PC_T0, 32'h0, 0); exp_q.push_back(8'h01); tick(); idle();
    exp_m = exp_q.pop_front(); n_tests++;
    if (bus.trig_match_e !== exp_m) begin
      n_fail++; $display("FAIL unchained_t0: got %h expected %h", bus.trig_match_e, exp_m);
    end
  endtask

  task automatic test_reset_mid();
    bus.trig_chain[0][0] = 1'b1;
    wr_cnt(0, 1, 8'd5);
    set_slot(0, PC_T0, 32'h0, 0); tick(); idle();
    n_tests++;
    if (bus.trig_armed !== 4'b0001 || bus.trig_cnt[0][1] !== 8'd5) begin
      n_fail++; $display("FAIL rst_prep: armed %b cnt %0d expected 0001 cnt 5",
                         bus.trig_armed, bus.trig_cnt[0][1]);
    end
    set_slot(1, PC_T1, 32'h0, 0); rst_l = 1'b0;
    exp_q.push_back(8'h00); tick(); idle(); rst_l = 1'b1;
    exp_m = exp_q.pop_front(); n_tests++;
    if (bus.trig_match_e !== exp_m || bus.trig_armed !== '0 || bus.trig_cnt !== '0) begin
      n_fail++; $display("FAIL rst_mid: match %h armed %b cnt %h expected all zero",
                         bus.trig_match_e, bus.trig_armed, bus.trig_cnt);
    end
    set_slot(0, PC_T0, 32'h0, 0); tick(); idle();
    set_slot(0, PC_T1, 32'h0, 0); exp_q.push_back(8'h02); tick(); idle();
    exp_m = exp_q.pop_front(); n_tests++;
    if (bus.trig_match_e !== exp_m || bus.trig_cnt[0][1] !== 8'd0) begin
      n_fail++; $display("FAIL rst_after: match %h cnt %0d expected %h cnt 0",
                         bus.trig_match_e, bus.trig_cnt[0][1], exp_m);
    end
  endtask

  task automatic test_mask();
    set_trig(0, 2, 1'b0, 1'b1, 1'b1, 32'h8000_05FF);
    set_slot(0, 32'h8000_04A0, 32'h0, 0); exp_q.push_back(8'h04); tick(); idle();
    exp_m = exp_q.pop_front(); n_tests++;
    if (bus.trig_match_e !== exp_m) begin
      n_fail++; $display("FAIL mask_hit: got %h expected %h", bus.trig_match_e, exp_m);
    end
    set_slot(0, 32'h8000_0800, 32'h0, 0); exp_q.push_back(8'h00); tick(); idle();
    exp_m = exp_q.pop_front(); n_tests++;
    if (bus.trig_match_e !== exp_m) begin
      n_fail++; $display("FAIL mask_miss: got %h expected %h", bus.trig_match_e, exp_m);
    end
    set_trig(0, 2, 1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  initial begin
    rst_l              = 1'b0;
    bus.trig_pkt       = '0;
    bus.trig_chain     = '0;
    bus.trig_cnt_wr    = '0;
    bus.trig_cnt_wdata = '0;
    bus.slot_valid     = '0;
    bus.slot_pc        = '0;
    bus.slot_instr     = '0;
    bus.slot_tid       = '0;
    bus.dec_flush      = '0;
    tick();
    tick();
    test_reset();
    rst_l = 1'b1;
    test_pc_match();
    test_threads();
    test_counter();
    test_dual_slot();
    test_chain();
    test_chain_same_cycle();
    test_reset_mid();
    test_mask();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/eh2_dec_trigger_seq.md
# eh2_dec_trigger_seq

Parametrised, stateful successor to the decode-stage trigger matcher. It adds PC/opcode match per slot and thread, hit counters with auto-reload, and sequential chaining of trigger pairs. The block sits in DEC between the decode slots and the TLU trigger/halt logic. Its matches are registered and qualified by per-thread flush.

## Interface
Parameters:
- NUM_THREADS, 1, hardware threads (1..2)
- NUM_TRIG, 4, triggers per thread (even, 2..8)
- NUM_SLOTS, 2, decode slots; slot 0 is oldest
- CNT_W, 8, hit-counter width

Ports:
- Clock and reset: one clock; reset is synchronous and active-low.
- clk  in  1  core clock
- rst_l  in  1  synchronous active-low reset, sampled on rising clk
- trig_pkt  in  NUM_THREADS x NUM_TRIG x eh2_trigger_pkt_t  select, execute, match, m, tdata2[31:0]
- trig_chain  in  NUM_THREADS x NUM_TRIG  chain bit; meaningful on even index only
- trig_cnt_wr  in  NUM_THREADS x NUM_TRIG  load pulse for counter/reload
- trig_cnt_wdata  in  CNT_W  value loaded into counter and reload register
- slot_valid  in  NUM_SLOTS  slot carries a legal instruction this cycle
- slot_pc  in  NUM_SLOTS x 31  pc[31:1]
- slot_instr  in  NUM_SLOTS x 32  opcode
- slot_tid  in  NUM_SLOTS x log2(NUM_THREADS) (min 1)  thread id
- dec_flush  in  NUM_THREADS  kill in-flight decode for thread
- trig_match_e  out  NUM_SLOTS x NUM_TRIG  registered fire per slot
- trig_armed  out  NUM_THREADS x NUM_TRIG/2  chain-armed state per pair
- trig_cnt  out  NUM_THREADS x NUM_TRIG x CNT_W  current counters (CSR read-back)

## Operation
- Raw match per slot s, trigger t, thread tid=slot_tid[s]:
  - Data is {slot_pc[s], tdata2[0]} when select=0, else slot_instr[s].
  - Match uses rvmaskandmatch against tdata2 with masken=match.
  - Qualified by slot_valid, execute, m, and ~dec_flush[tid].
- Counter: cnt=0 means fire on every raw match. With cnt>0, each raw match decrements cnt; the match that sees cnt==1 fires, and cnt then reloads from the reload register. A reload of 0 leaves subsequent matches firing every time.
- Same-cycle multi-slot, same thread and trigger: slots are evaluated in order. Slot 1 sees the counter value as updated by slot 0's match, including any reload. The final cnt reflects all matches.
- Chain, pair (2k, 2k+1), when trig_chain[2k]=1:
  - A fire of 2k sets armed[k] and suppresses trigger 2k's own output.
  - Trigger 2k+1 may decrement or fire only while armed, or when an older slot fires 2k in the same cycle.
  - A fire of 2k+1 clears armed[k].
  - If one slot fires both 2k and 2k+1, armed is set and the output is suppressed; the next 2k+1 match fires.
- armed[k] is cleared on:
  - dec_flush[tid];
  - trig_cnt_wr on either trigger of the pair;
  - trig_chain[2k] deasserting.
  - Clear has priority over set in the same cycle.
- trig_cnt_wr has priority over decrement in the same cycle. The write loads both cnt and reload.
- Unchained pairs behave as independent triggers.

## Timing
- Raw match and counter/chain evaluation are combinational in cycle D.
- trig_match_e is registered and valid in cycle D+1.
- Counter and armed updates are visible in D+1.
- dec_flush in cycle D kills that cycle's matches. dec_flush in D+1 for the slot's thread forces trig_match_e to 0 for that slot in D+1; state updates from D stand.
- Reset values: trig_match_e=0, trig_armed=0, trig_cnt=0, reload registers=0.
- Reset asserted mid-sequence clears all state at the next edge. There is no partial update.
- There is no handshake and no back-pressure; every cycle is evaluated.

## Test plan
- T0 execute=1, m=1, select=0, match=0, tdata2=0x80000100; slot0 pc=0x80000100 valid in cycle 5 -> trig_match_e[0][0]=1 in cycle 6 only; pc 0x80000104 -> no fire.
- Counter: write 3 to T1 (opcode select). Three matching instructions in consecutive cycles -> fires on the third only; trig_cnt sequence 3,2,1,3 (reloaded).
- Dual-slot counter: cnt=1, reload=2, both slots match T1 same cycle -> slot0 fires, slot1 no fire, cnt=1 next cycle.
- Chain: trig_chain[0]=1. A T1-matching PC first -> no fire. Then a T0 match -> armed[0]=1, no output. Then a T1 match -> slot fire on T1, armed[0]=0.
- Chain same cycle: slot0 matches T0, slot1 matches T1 -> slot1 T1 fires in D+1, armed ends 0. Repeat with a dec_flush pulse between arming and the T1 match -> no fire, armed=0.
- Reset: arm pair 0 and set cnt=5, assert rst_l=0 for one cycle -> trig_armed=0, trig_cnt=0, trig_match_e=0 next cycle.
